json_stream_checker: RTL and testbench
======================================

// Module: json_stream_checker
// PURPOSE
//  Streaming JSON syntax checker: one byte/cycle over valid/ready, validated with an FSM plus a container stack.
//  Hardware companion to json_pkg: result codes are the numeric JSONStatus values, so a bench can compare against JSONValue parse().
//  Sits between a byte source (DMA/UART/file BFM) and any consumer that must reject malformed documents before decoding.
// PARAMETERS
//  MAX_DEPTH  32  max object/array nesting; exceeding it -> CHECK_DEPTH_ERROR (14)
//  DEPTH_W    $clog2(MAX_DEPTH+1)  width of depth counter/outputs
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  in_valid    in   1        byte valid
//  in_ready    out  1        byte accepted when in_valid&&in_ready
//  in_data     in   8        ASCII byte
//  in_last     in   1        last byte of document (qualified by in_valid)
//  res_valid   out  1        result available; held until res_ready
//  res_ready   in   1        result consumed
//  res_status  out  5        JSONStatus code (0,1,2,3,4,5,6,7,8,14)
//  res_depth   out  DEPTH_W  nesting depth at first error (0 if OK)
// BEHAVIOUR
//  Reset: in_ready=0 during reset, 1 on first clk after release; res_valid=0, res_status=0, res_depth=0, FSM=S_VALUE, depth=0.
//  Handshake: in_ready = !res_valid. Result registered: res_valid rises the cycle after last byte accepted; drops the cycle after res_valid&&res_ready; next document starts then.
//  States: S_VALUE(expect value), S_KEY(expect '"' or '}' if first), S_COLON, S_AFTER(expect ',' or closer), S_STR, S_ESC, S_LIT, S_NUM, S_END(root done, only whitespace), S_FLUSH(error latched, discard to in_last).
//  Whitespace (0x20,0x09,0x0A,0x0D) skipped in S_VALUE/S_KEY/S_COLON/S_AFTER/S_END.
//  S_VALUE: '{'->push 0,S_KEY; '['->push 1,S_VALUE(']' allowed only directly after '['); '"'->S_STR; t/f/n->S_LIT; '-'/digit->S_NUM; else INVALID_VALUE(2).
//  S_LIT: 4-bit index into "true"/"false"/"null"; mismatch->2; complete->S_AFTER (or S_END at depth 0).
//  S_NUM: accepts [0-9.eE+-]; any other byte terminates the number and is re-evaluated same cycle as S_AFTER/S_END (no stall).
//  S_STR: '\\'->S_ESC (next byte accepted unconditionally); '"' ends string: key->S_COLON, value->S_AFTER/S_END; bytes <0x20 ->2.
//  S_KEY non-quote -> MISS_KEY(3). S_COLON non-':' -> MISS_COLON(4).
//  S_AFTER: ','->S_KEY (top=obj) or S_VALUE (top=arr); matching closer pops; mismatch -> 5 (top=obj) or 7 (top=arr).
//  Push when depth==MAX_DEPTH -> CHECK_DEPTH_ERROR(14). Stack: MAX_DEPTH x 1 bit (0=obj,1=arr), depth counter saturates, never wraps.
//  S_END non-whitespace -> ROOT_NOT_SINGULAR(1).
//  in_last resolution (final byte processed first): clean in S_END -> 0; S_VALUE at depth 0 with no value seen -> NO_VALUE(8);
//   in S_STR/S_ESC -> MISS_QUOTATION_MARK(6); S_NUM/complete S_LIT at depth 0 -> 0; else open container -> 5/7 by top of stack.
//  First error wins: latched with depth, FSM -> S_FLUSH, bytes consumed and dropped until in_last; error on last byte reports immediately.
//  in_valid low: no state change. rst_n low mid-document: all state cleared asynchronously, partial document discarded, no result.
// CONFIGURATION
//  JSON_CHECK_STATS_EN defined: extra outputs stat_values[15:0] (scalar+container values completed) and stat_max_depth[DEPTH_W-1:0],
//   valid with res_valid, cleared at document start; counters saturate at all-ones.
//  Undefined: ports and counters absent; core behaviour identical.
// TESTING
//  {"a":[1,true,null]} last on '}' -> res_status=0, res_depth=0, res_valid 1 cycle after '}'.
//  "  " then in_last -> status 8; "1 2" -> status 1 at depth 0; "tru" + last -> status 2.
//  {"a" 1} -> status 4, depth 1; {"a":1 "b":2} -> 5; [1 2] -> 7; {1:2} -> 3; "abc + last -> 6.
//  MAX_DEPTH=4, "[[[[[" -> 14 with res_depth=4; trailing bytes flushed with in_ready=1 until in_last.
//  Hold res_ready=0 for 10 cycles -> res_valid/res_status stable, in_ready=0; release -> next doc accepted.
//  Reset asserted mid "{"a":" -> outputs at reset values; following doc "[]" -> status 0 (with _EN: stat_values=1, stat_max_depth=1).

Source files
------------

// File: rtl/json_stream_checker.sv
// Streaming JSON syntax checker, one byte per cycle; result registered one cycle after the last byte.
// Input stalls (in_ready=0) while a result is pending; optional stats outputs under JSON_CHECK_STATS_EN.
module json_stream_checker #(
    parameter int MAX_DEPTH = 32,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [4:0]         res_status,
    output logic [DEPTH_W-1:0] res_depth
`ifdef JSON_CHECK_STATS_EN
    ,
    output logic [15:0]        stat_values,
    output logic [DEPTH_W-1:0] stat_max_depth
`endif
);

    localparam logic [4:0] ST_OK    = 5'd0;
    localparam logic [4:0] ST_ROOT  = 5'd1;
    localparam logic [4:0] ST_INV   = 5'd2;
    localparam logic [4:0] ST_KEY   = 5'd3;
    localparam logic [4:0] ST_COLON = 5'd4;
    localparam logic [4:0] ST_OBJ   = 5'd5;
    localparam logic [4:0] ST_QUOTE = 5'd6;
    localparam logic [4:0] ST_ARR   = 5'd7;
    localparam logic [4:0] ST_NOVAL = 5'd8;
    localparam logic [4:0] ST_DEPTH = 5'd14;

    typedef enum logic [3:0] {
        S_VALUE, S_KEY, S_COLON, S_AFTER, S_STR, S_ESC, S_LIT, S_NUM, S_END, S_FLUSH
    } state_t;

    state_t               state_q, state_d, ev_state;
    logic [DEPTH_W-1:0]   depth_q, depth_d, depth_pre;
    logic [MAX_DEPTH-1:0] stack_q, stack_d;
    logic                 first_q, first_d, key_q, key_d;
    logic [1:0]           lit_sel_q, lit_sel_d;
    logic [3:0]           lit_idx_q, lit_idx_d;
    logic                 rdy_q;
    logic                 res_valid_q, res_valid_d;
    logic [4:0]           res_status_q, res_status_d;
    logic [DEPTH_W-1:0]   res_depth_q, res_depth_d;
    logic                 fire, ws, num_ch, top_q, num_end;
    logic                 do_push, push_arr, do_pop, val_end, err;
    logic [4:0]           err_code, last_code;

    // Stack bit at the given depth: 1 = array, 0 = object (0 when empty).
    function automatic logic top_of(input logic [MAX_DEPTH-1:0] stk, input logic [DEPTH_W-1:0] d);
        top_of = 1'b0;
        for (int i = 0; i < MAX_DEPTH; i++)
            if (d == DEPTH_W'(i + 1)) top_of = stk[i];
    endfunction

    function automatic logic [7:0] lit_char(input logic [1:0] sel, input logic [3:0] idx);
        logic [39:0] word;
        case (sel)
            2'd0:    word = {"true", 8'h00};
            2'd1:    word = "false";
            default: word = {"null", 8'h00};
        endcase
        case (idx)
            4'd1:    lit_char = word[31:24];
            4'd2:    lit_char = word[23:16];
            4'd3:    lit_char = word[15:8];
            4'd4:    lit_char = word[7:0];
            default: lit_char = word[39:32];
        endcase
    endfunction

    assign fire   = in_valid & in_ready;
    assign ws     = (in_data == 8'h20) | (in_data == 8'h09) | (in_data == 8'h0A) | (in_data == 8'h0D);
    assign num_ch = ((in_data >= "0") && (in_data <= "9")) | (in_data == ".") | (in_data == "e") |
                    (in_data == "E") | (in_data == "+") | (in_data == "-");
    assign top_q  = top_of(stack_q, depth_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_VALUE;
            depth_q      <= '0;
            stack_q      <= '0;
            first_q      <= 1'b0;
            key_q        <= 1'b0;
            lit_sel_q    <= 2'd0;
            lit_idx_q    <= 4'd0;
            rdy_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            res_status_q <= ST_OK;
            res_depth_q  <= '0;
        end else begin
            state_q      <= state_d;
            depth_q      <= depth_d;
            stack_q      <= stack_d;
            first_q      <= first_d;
            key_q        <= key_d;
            lit_sel_q    <= lit_sel_d;
            lit_idx_q    <= lit_idx_d;
            rdy_q        <= 1'b1;
            res_valid_q  <= res_valid_d;
            res_status_q <= res_status_d;
            res_depth_q  <= res_depth_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        depth_d      = depth_q;
        stack_d      = stack_q;
        first_d      = first_q;
        key_d        = key_q;
        lit_sel_d    = lit_sel_q;
        lit_idx_d    = lit_idx_q;
        res_valid_d  = res_valid_q;
        res_status_d = res_status_q;
        res_depth_d  = res_depth_q;
        do_push      = 1'b0;
        push_arr     = 1'b0;
        do_pop       = 1'b0;
        val_end      = 1'b0;
        err          = 1'b0;
        err_code     = ST_OK;
        last_code    = ST_OK;
        depth_pre    = depth_q;
        // A byte that ends a number is judged as if the number had already closed.
        num_end  = (state_q == S_NUM) && !num_ch;
        ev_state = num_end ? ((depth_q == '0) ? S_END : S_AFTER) : state_q;
        if (res_valid_q && res_ready) res_valid_d = 1'b0;
        if (fire) begin
            state_d = ev_state;
            if (!ws) first_d = 1'b0;
            case (ev_state)
                S_VALUE: if (!ws) begin
                    if (in_data == "{") do_push = 1'b1;
                    else if (in_data == "[") begin do_push = 1'b1; push_arr = 1'b1; end
                    else if ((in_data == "]") && first_q) do_pop = 1'b1;
                    else if (in_data == "\"") begin key_d = 1'b0; state_d = S_STR; end
                    else if ((in_data == "t") || (in_data == "f") || (in_data == "n")) begin
                        state_d   = S_LIT;
                        lit_idx_d = 4'd1;
                        lit_sel_d = (in_data == "t") ? 2'd0 : (in_data == "f") ? 2'd1 : 2'd2;
                    end
                    else if ((in_data == "-") || ((in_data >= "0") && (in_data <= "9"))) state_d = S_NUM;
                    else begin err = 1'b1; err_code = ST_INV; end
                end
                S_KEY: if (!ws) begin
                    if (in_data == "\"") begin key_d = 1'b1; state_d = S_STR; end
                    else if ((in_data == "}") && first_q) do_pop = 1'b1;
                    else begin err = 1'b1; err_code = ST_KEY; end
                end
                S_COLON: if (!ws) begin
                    if (in_data == ":") state_d = S_VALUE;
                    else begin err = 1'b1; err_code = ST_COLON; end
                end
                S_AFTER: if (!ws) begin
                    if (in_data == ",") state_d = top_q ? S_VALUE : S_KEY;
                    else if ((in_data == "}") && !top_q) do_pop = 1'b1;
                    else if ((in_data == "]") && top_q) do_pop = 1'b1;
                    else begin err = 1'b1; err_code = top_q ? ST_ARR : ST_OBJ; end
                end
                S_STR: begin
                    if (in_data == "\\") state_d = S_ESC;
                    else if (in_data == "\"") begin
                        if (key_q) state_d = S_COLON;
                        else val_end = 1'b1;
                    end
                    else if (in_data < 8'h20) begin err = 1'b1; err_code = ST_INV; end
                end
                S_ESC: state_d = S_STR;
                S_LIT: begin
                    if (in_data != lit_char(lit_sel_q, lit_idx_q)) begin err = 1'b1; err_code = ST_INV; end
                    else if (lit_idx_q == ((lit_sel_q == 2'd1) ? 4'd4 : 4'd3)) val_end = 1'b1;
                    else lit_idx_d = lit_idx_q + 4'd1;
                end
                S_END: if (!ws) begin err = 1'b1; err_code = ST_ROOT; end
                default: ;
            endcase
            if (do_push) begin
                if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                    err      = 1'b1;
                    err_code = ST_DEPTH;
                end else begin
                    depth_pre = depth_q + 1'b1;
                    for (int i = 0; i < MAX_DEPTH; i++)
                        if (depth_q == DEPTH_W'(i)) stack_d[i] = push_arr;
                    first_d = 1'b1;
                    state_d = push_arr ? S_VALUE : S_KEY;
                end
            end
            if (do_pop) begin
                depth_pre = depth_q - 1'b1;
                state_d   = (depth_q == DEPTH_W'(1)) ? S_END : S_AFTER;
            end
            if (val_end) state_d = (depth_q == '0) ? S_END : S_AFTER;
            if (err) begin
                state_d      = S_FLUSH;
                res_status_d = err_code;
                res_depth_d  = depth_q;
            end
            depth_d = depth_pre;
            if (in_last) begin
                res_valid_d = 1'b1;
                if ((state_q != S_FLUSH) && !err) begin
                    case (state_d)
                        S_END:        last_code = ST_OK;
                        S_VALUE:      last_code = (depth_pre == '0) ? ST_NOVAL :
                                                  (top_of(stack_d, depth_pre) ? ST_ARR : ST_OBJ);
                        S_STR, S_ESC: last_code = ST_QUOTE;
                        S_LIT:        last_code = ST_INV;
                        S_NUM:        last_code = (depth_pre == '0) ? ST_OK :
                                                  (top_of(stack_d, depth_pre) ? ST_ARR : ST_OBJ);
                        default:      last_code = top_of(stack_d, depth_pre) ? ST_ARR : ST_OBJ;
                    endcase
                    res_status_d = last_code;
                    res_depth_d  = (last_code == ST_OK) ? '0 : depth_pre;
                end
                state_d = S_VALUE;
                depth_d = '0;
                first_d = 1'b0;
            end
        end
    end

    always_comb begin
        in_ready   = rdy_q & ~res_valid_q;
        res_valid  = res_valid_q;
        res_status = res_status_q;
        res_depth  = res_depth_q;
    end

`ifdef JSON_CHECK_STATS_EN
    logic [15:0]        stat_values_q;
    logic [DEPTH_W-1:0] stat_max_q;
    logic               num_last;
    logic [1:0]         stat_add;
    logic [16:0]        stat_sum;

    // A closer can end a number and its container in the same byte, hence up to two per cycle.
    assign num_last = (state_q == S_NUM) && num_ch && in_last;
    assign stat_add = {1'b0, num_end} + {1'b0, (do_pop | val_end | num_last)};
    assign stat_sum = {1'b0, stat_values_q} + {15'd0, stat_add};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_values_q <= '0;
            stat_max_q    <= '0;
        end else if (res_valid_q && res_ready) begin
            stat_values_q <= '0;
            stat_max_q    <= '0;
        end else if (fire && (state_q != S_FLUSH)) begin
            stat_values_q <= stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
            if (depth_pre > stat_max_q) stat_max_q <= depth_pre;
        end
    end

    assign stat_values    = stat_values_q;
    assign stat_max_depth = stat_max_q;
`endif

endmodule

// File: tb/tb_json_stream_checker.sv
// Bench for json_stream_checker (MAX_DEPTH=4): fixed vectors, corner sequences, generated documents.
module tb_json_stream_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [4:0] res_status;
    logic [2:0] res_depth;
`ifdef JSON_CHECK_STATS_EN
    logic [15:0] stat_values;
    logic [2:0]  stat_max_depth;
`endif

    json_stream_checker #(.MAX_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status), .res_depth(res_depth)
`ifdef JSON_CHECK_STATS_EN
        , .stat_values(stat_values), .stat_max_depth(stat_max_depth)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string doc;
        int    st;
        int    dp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] doc_q[$];
    int         total = 0;
    int         bad = 0;
    int         g_vals;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void emit(input string s);
        for (int i = 0; i < s.len(); i++) doc_q.push_back(s[i]);
    endfunction

    function automatic void emit_ws();
        case ($urandom_range(0, 5))
            0: emit(" ");
            1: emit("\t");
            2: emit("\n");
            3: emit("\r");
            default: ;
        endcase
    endfunction

    function automatic void emit_scalar();
        case ($urandom_range(0, 5))
            0: emit("1");
            1: emit("-20.5e+3");
            2: emit("true");
            3: emit("false");
            4: emit("null");
            default: emit("\"s\\\"q\"");
        endcase
        g_vals++;
    endfunction

    function automatic void member(input bit is_obj);
        if (is_obj) begin
            emit("\"k\"");
            emit_ws();
            emit(":");
            emit_ws();
        end
        emit_scalar();
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic last);
        int budget;
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) begin
                in_data = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        budget   = 0;
        while (!in_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_doc();
        for (int i = 0; i < doc_q.size(); i++)
            send_byte(doc_q[i], i == doc_q.size() - 1);
    endtask

    task automatic load(input string s);
        doc_q.delete();
        emit(s);
    endtask

    task automatic get_result(input string name, input int st, input int dp, input bit lat,
                              input bit stats, input int vals, input int mx);
        int waited = 0;
        while (!res_valid && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!res_valid) begin
            chk({name, "_res_timeout"}, 0, 1);
        end else begin
            chk({name, "_status"}, res_status, st);
            chk({name, "_depth"}, res_depth, dp);
            if (lat) chk({name, "_latency"}, waited, 0);
`ifdef JSON_CHECK_STATS_EN
            if (stats) begin
                chk({name, "_stat_values"}, stat_values, vals);
                chk({name, "_stat_max"}, stat_max_depth, mx);
            end
`else
            if (stats && (vals < 0 || mx < 0)) chk({name, "_stat_args"}, 0, 1);
`endif
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
        end
    endtask

    initial begin
        int c[4];
        int n, k, r, mode, close_idx, est, edp;

        // Reset state.
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_status", res_status, 0);
        chk("rst_res_depth", res_depth, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);

        vecs.push_back('{doc: "{\"a\":[1,true,null]}", st: 0, dp: 0});
        vecs.push_back('{doc: "  ", st: 8, dp: 0});
        vecs.push_back('{doc: "1 2", st: 1, dp: 0});
        vecs.push_back('{doc: "tru", st: 2, dp: 0});
        vecs.push_back('{doc: "{\"a\" 1}", st: 4, dp: 1});
        vecs.push_back('{doc: "{\"a\":1 \"b\":2}", st: 5, dp: 1});
        vecs.push_back('{doc: "[1 2]", st: 7, dp: 1});
        vecs.push_back('{doc: "{1:2}", st: 3, dp: 1});
        vecs.push_back('{doc: "\"abc", st: 6, dp: 0});
        vecs.push_back('{doc: "[[[[[", st: 14, dp: 4});
        vecs.push_back('{doc: "[[[[]]]]", st: 0, dp: 0});
        vecs.push_back('{doc: " [ ] ", st: 0, dp: 0});
        vecs.push_back('{doc: "{}", st: 0, dp: 0});
        vecs.push_back('{doc: "[1,]", st: 2, dp: 1});
        vecs.push_back('{doc: "[1,2", st: 7, dp: 1});
        vecs.push_back('{doc: "{\"k\":\"v\\\"x\"}", st: 0, dp: 0});
        vecs.push_back('{doc: "false", st: 0, dp: 0});
        vecs.push_back('{doc: "nul", st: 2, dp: 0});
        vecs.push_back('{doc: "-1.5e+3", st: 0, dp: 0});
        vecs.push_back('{doc: "{\"a\":{\"b\":[]}}", st: 0, dp: 0});
        vecs.push_back('{doc: "]", st: 2, dp: 0});
        vecs.push_back('{doc: "{\"a\":1,}", st: 3, dp: 1});
        vecs.push_back('{doc: "[1]]", st: 1, dp: 0});
        vecs.push_back('{doc: "{\"a\":tX}", st: 2, dp: 1});
        vecs.push_back('{doc: "[1}]", st: 7, dp: 1});
        vecs.push_back('{doc: "{", st: 5, dp: 1});
        vecs.push_back('{doc: "[", st: 7, dp: 1});

        foreach (vecs[i]) begin
            load(vecs[i].doc);
            send_doc();
            get_result($sformatf("vec%0d", i), vecs[i].st, vecs[i].dp, 1'b1, 1'b0, 0, 0);
        end

        // Depth overflow, then trailing bytes are swallowed until in_last.
        load("[[[[[");
        foreach (doc_q[i]) send_byte(doc_q[i], 1'b0);
        load("ab}");
        foreach (doc_q[i]) begin
            chk("flush_in_ready", in_ready, 1);
            chk("flush_res_valid", res_valid, 0);
            send_byte(doc_q[i], i == 2);
        end
        get_result("overflow_flush", 14, 4, 1'b1, 1'b0, 0, 0);

        // Result held while the consumer stalls.
        load("x");
        send_doc();
        in_valid = 1'b1;
        in_data  = "[";
        for (int i = 0; i < 10; i++) begin
            chk("hold_outputs", int'({res_valid, in_ready, res_status, res_depth}),
                int'({1'b1, 1'b0, 5'd2, 3'd0}));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("release_res_valid", res_valid, 0);
        chk("release_in_ready", in_ready, 1);
        load("[]");
        send_doc();
        get_result("after_hold", 0, 0, 1'b1, 1'b0, 0, 0);

        // Reset in the middle of a document.
        load("{\"a\":");
        foreach (doc_q[i]) send_byte(doc_q[i], 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_res_status", res_status, 0);
        chk("midrst_res_depth", res_depth, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        load("[]");
        send_doc();
        get_result("after_rst", 0, 0, 1'b1, 1'b1, 1, 1);

        // Generated documents with known structure and optional planted faults.
        for (int t = 0; t < 60; t++) begin
            doc_q.delete();
            g_vals    = 0;
            close_idx = 0;
            n = $urandom_range(0, 4);
            for (int i = 0; i < 4; i++) c[i] = $urandom_range(0, 1);
            emit_ws();
            if (n == 0) begin
                emit_scalar();
            end else begin
                for (int i = 0; i < n; i++) begin
                    emit(c[i] ? "[" : "{");
                    emit_ws();
                    k = $urandom_range(0, 2);
                    if (i == n - 1) begin
                        for (int j = 0; j < k; j++) begin
                            if (j > 0) emit(",");
                            emit_ws();
                            member(c[i] == 0);
                        end
                    end else begin
                        for (int j = 0; j < k; j++) begin
                            member(c[i] == 0);
                            emit(",");
                            emit_ws();
                        end
                        if (c[i] == 0) emit("\"k\":");
                    end
                end
                for (int i = n - 1; i >= 0; i--) begin
                    emit_ws();
                    emit(c[i] ? "]" : "}");
                    if (i == 0) begin
                        close_idx = doc_q.size() - 1;
                    end else begin
                        r = $urandom_range(0, 1);
                        for (int j = 0; j < r; j++) begin
                            emit(",");
                            emit_ws();
                            member(c[i - 1] == 0);
                        end
                    end
                end
            end
            g_vals += n;
            emit_ws();
            mode = $urandom_range(0, 3);
            if (mode == 2 && n == 0) mode = 0;
            est = 0;
            edp = 0;
            case (mode)
                1: begin emit(" 7"); est = 1; end
                2: begin doc_q.delete(close_idx); est = c[0] ? 7 : 5; edp = 1; end
                3: begin repeat (5) doc_q.push_front("["); est = 14; edp = 4; end
                default: ;
            endcase
            send_doc();
            get_result($sformatf("rand%0d_m%0d", t, mode), est, edp, 1'b1, mode == 0, g_vals, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
